vdp_layer_split_scheduler: RTL
==============================

// Module: vdp_layer_split_scheduler
// PURPOSE
//  Drives layer_enable/layer_mask of the VDP priority compute stage per scanline.
//  The CPU programs a base config plus a table of raster-split entries.
//  Tables are double-buffered and committed at frame start, so the picture never tears.
//  On each line start the active table is scanned and matching entries are applied; the
//  applied config persists until the next split or frame start.
// PARAMETERS
//  ENTRIES     4   split table depth (power of 2, >=2)
//  LINE_BITS   9   raster line counter width
// PORTS
//  clk              in   1          VDP clock
//  reset            in   1          sync, active-high
//  base_write_en    in   1          write pending base config
//  base_enable      in   5          pending base layer_enable
//  base_mask        in   5          pending base layer_mask
//  split_write_en   in   1          write pending split entry
//  split_index      in   log2(ENTRIES)  entry index
//  split_valid      in   1          entry valid bit
//  split_line       in   LINE_BITS  raster line at which entry applies
//  split_enable     in   5          layer_enable applied on hit
//  split_mask       in   5          layer_mask applied on hit
//  frame_start      in   1          1-cycle pulse, start of frame
//  line_start       in   1          1-cycle pulse, start of line (before active pixels)
//  raster_y         in   LINE_BITS  line number qualified by line_start
//  layer_enable     out  5          to priority compute
//  layer_mask       out  5          to priority compute
//  busy             out  1          scan in progress
//  split_hit        out  1          1-cycle pulse, a split was applied
//  split_hit_index  out  log2(ENTRIES)  index of winning entry (valid with split_hit)
//  overrun          out  1          sticky: line_start arrived while busy
// BEHAVIOUR
//  - Reset values:
//    - layer_enable=0, layer_mask=5'h1f, busy=0, split_hit=0, split_hit_index=0, overrun=0.
//    - Pending and active base = {enable 0, mask 5'h1f}.
//    - All pending and active entries invalid.
//    - FSM returns to IDLE. Reset mid-scan aborts the scan with no apply.
//  - Writes update only pending storage; outputs never change on a write.
//    - base_write_en and split_write_en may assert together; both take effect.
//  - Commit (frame_start sampled at edge E):
//    - Active base and active table <= pending as held before E.
//    - A write in the same cycle as frame_start lands in pending only (next frame).
//    - layer_enable/mask <= pending base, visible after E.
//    - overrun is not cleared.
//  - FSM states: IDLE, SCAN, APPLY.
//    - IDLE: line_start -> latch raster_y, idx=0, clear hit -> SCAN.
//    - SCAN: one entry per cycle, idx 0..ENTRIES-1. An entry hits if valid and
//      line == latched line. A later hit overwrites an earlier one, so the highest
//      index wins. After idx=ENTRIES-1 -> APPLY.
//    - APPLY: on a hit, layer_enable/mask <= entry values and split_hit=1 for one
//      cycle with split_hit_index; with no hit, outputs are held. -> IDLE.
//  - busy=1 in SCAN and APPLY.
//  - Latency: line_start at edge E0 -> new config visible after edge E0+ENTRIES+1.
//  - Required line_start spacing is >= ENTRIES+2 cycles.
//  - line_start while busy: overrun<=1 (sticky until reset), the current scan is
//    aborted, and a new scan restarts with the new raster_y. Nothing is applied from
//    the aborted scan.
//  - frame_start and line_start in the same cycle: commit first, then the scan uses
//    the newly committed table.
//  - frame_start while busy: commit occurs, outputs <= base, and the in-flight scan is
//    aborted (no apply).
//  - Line compare is exact LINE_BITS equality, with no wrap. Entries with a line never
//    reached simply never hit.
// TESTING
//  - Reset, then idle 10 cycles -> layer_enable=0, layer_mask=1f, busy=0, overrun=0.
//  - Write base {en 1f, mask 0f}, then frame_start -> outputs 1f/0f one cycle later.
//    Before frame_start the outputs are unchanged.
//  - Entry 1 {line 20, en 03, mask 01} committed; line_start y=19 -> no change.
//    line_start y=20 -> outputs 03/01 at +ENTRIES+1 with split_hit=1, index=1.
//    y=21 -> outputs stay 03/01.
//  - Entries 0 and 3 both line 50 (en 05 / en 0a) -> after y=50 the output is 0a,
//    split_hit_index=3.
//  - Second line_start 2 cycles after the first -> overrun=1; only the second line's
//    result is applied.
//  - Split write in the frame_start cycle -> ignored this frame, applied after the
//    next frame_start.

Source files
------------

// File: rtl/vdp_layer_split_scheduler.sv
// vdp_layer_split_scheduler: per-scanline layer_enable/layer_mask from a double-buffered raster-split table
// Ports: clk/reset (sync, active-high); base_* and split_* write the pending config;
// frame_start commits pending to active; line_start/raster_y trigger a table scan;
// layer_enable/layer_mask feed priority compute; busy, split_hit(_index) and sticky overrun report status.
module vdp_layer_split_scheduler #(
  parameter int ENTRIES   = 4,
  parameter int LINE_BITS = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       base_write_en,
  input  logic [4:0]                 base_enable,
  input  logic [4:0]                 base_mask,
  input  logic                       split_write_en,
  input  logic [$clog2(ENTRIES)-1:0] split_index,
  input  logic                       split_valid,
  input  logic [LINE_BITS-1:0]       split_line,
  input  logic [4:0]                 split_enable,
  input  logic [4:0]                 split_mask,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic [LINE_BITS-1:0]       raster_y,
  output logic [4:0]                 layer_enable,
  output logic [4:0]                 layer_mask,
  output logic                       busy,
  output logic                       split_hit,
  output logic [$clog2(ENTRIES)-1:0] split_hit_index,
  output logic                       overrun
);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
  typedef struct packed {
    logic                 v;
    logic [LINE_BITS-1:0] line;
    logic [4:0]           en;
    logic [4:0]           mask;
  } entry_t;
  state_t state, state_n;
  entry_t pend [ENTRIES];
  entry_t act [ENTRIES];
  logic [4:0] base_en, base_msk;
  logic [IW-1:0] idx, hit_idx;
  logic [LINE_BITS-1:0] y_lat;
  logic hit, last, entry_hit;
  assign busy = state != IDLE;
  assign last = idx == IW'(ENTRIES - 1);
  assign entry_hit = act[idx].v && act[idx].line == y_lat;
  // line_start always (re)starts a scan; frame_start aborts any scan in flight
  always_comb begin
    state_n = line_start ? SCAN :
              frame_start ? IDLE :
              (state == SCAN && last) ? APPLY :
              state == APPLY ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
      base_en         <= '0;
      base_msk        <= '1;
      layer_enable    <= '0;
      layer_mask      <= '1;
      idx             <= '0;
      hit_idx         <= '0;
      y_lat           <= '0;
      hit             <= 1'b0;
      split_hit       <= 1'b0;
      split_hit_index <= '0;
      overrun         <= 1'b0;
    end else begin
      split_hit <= 1'b0;
      if (base_write_en) begin
        base_en  <= base_enable;
        base_msk <= base_mask;
      end
      if (split_write_en) pend[split_index] <= {split_valid, split_line, split_enable, split_mask};
      // the commit reads pending as held before this edge, so same-cycle writes wait a frame
      if (frame_start) begin
        act          <= pend;
        layer_enable <= base_en;
        layer_mask   <= base_msk;
      end else if (state == APPLY && hit && !line_start) begin
        layer_enable    <= act[hit_idx].en;
        layer_mask      <= act[hit_idx].mask;
        split_hit       <= 1'b1;
        split_hit_index <= hit_idx;
      end
      if (line_start) begin
        overrun <= overrun | busy;
        y_lat   <= raster_y;
        idx     <= '0;
        hit     <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (entry_hit) begin
          hit     <= 1'b1;
          hit_idx <= idx;
        end
      end
    end
  end
endmodule
